// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller.
// Holds the program counter and drives it straight onto the address of a
// combinational instruction memory. Each fetched word is registered into IR
// for the decode stage, with a valid/ready handshake between the two.
// A HALT_WORD stops fetching. A branch redirects the PC and flushes any
// instruction still waiting for decode.
module instr_fetch_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              valid,
    input  logic              ready,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              is_halt;

    // The memory is read combinationally, so the address is always the PC itself
    assign address = pc;

    // IR may take a new word when it is empty or decode is consuming it this cycle
    assign load    = !valid || ready;
    assign is_halt = (instruction == HALT_WORD);

    // Control FSM: PC, IR and the handshake flags all move together on the clock edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            ir_addr <= '0;
            valid   <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc    <= '0;
                    valid <= 1'b0;
                    if (start) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (branch) begin
                        pc    <= target;
                        valid <= 1'b0;
                    end else if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        if (load) begin
                            valid <= 1'b0;
                        end
                    end else if (load) begin
                        ir      <= instruction;
                        ir_addr <= pc;
                        valid   <= 1'b1;
                        pc      <= pc + 1'b1;
                    end
                end

                HALT: begin
                    if (branch) begin
                        pc     <= target;
                        halted <= 1'b0;
                        valid  <= 1'b0;
                        state  <= FETCH;
                    end else if (ready) begin
                        valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the instruction memory address width (32 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the instruction code that stops fetching.
REQ-004 Clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 Rst_n  input  1  reset, synchronous and active-low.
REQ-006 Start  input  1  begins fetching from address 0 when the block is idle.
REQ-007 Address  output  ADDR_W  read address to the combinational instruction memory; always equal to PC.
REQ-008 Instruction  input  DATA_W  memory read data, valid in the same cycle as Address.
REQ-009 IR  output  DATA_W  registered instruction presented to decode.
REQ-010 IRAddr  output  ADDR_W  address from which IR was fetched.
REQ-011 Valid  output  1  IR holds an instruction that decode has not yet accepted.
REQ-012 Ready  input  1  decode accepts IR this cycle when Valid=1.
REQ-013 Branch  input  1  redirect request, one cycle wide.
REQ-014 Target  input  ADDR_W  redirect address, sampled when Branch=1.
REQ-015 Halted  output  1  a HALT_WORD has been fetched and fetching has stopped.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH and HALT.
REQ-017 IDLE: PC=0, Valid=0; Start=1 -> FETCH next cycle; Branch is ignored.
REQ-018 FETCH, load condition (Valid=0 or Ready=1): IR<=Instruction, IRAddr<=PC, Valid<=1, PC<=PC+1.
REQ-019 FETCH, stall (Valid=1 and Ready=0): IR, IRAddr, Valid and PC SHALL hold their values.
REQ-020 Fetch latency SHALL be one cycle (Address presented in cycle n; IR/Valid updated at end of cycle n); with Ready held at 1, throughput SHALL be one instruction per cycle.
REQ-021 PC arithmetic SHALL be modulo 2^ADDR_W (31+1 -> 0, no flag).
REQ-022 FETCH, load condition with Instruction==HALT_WORD: state->HALT, Halted<=1, PC holds, and the halt word SHALL NOT be loaded into IR. Valid<=0 unless the pending IR is stalled (Ready=0), in which case IR/Valid hold until Ready=1 and Valid then clears.
REQ-023 Branch=1 in FETCH SHALL override stall and halt detection: PC<=Target, Valid<=0 (flush of the pending IR), and the current Instruction is discarded.
REQ-024 Branch=1 in HALT: PC<=Target, Halted<=0, state->FETCH.
REQ-025 Start=1 outside IDLE SHALL be ignored.
REQ-026 Start and Branch asserted together in IDLE: Start wins, PC=0.

Reset
REQ-027 When Rst_n=0 at a rising edge, the block SHALL enter IDLE with PC=0, Address=0, IR=0, IRAddr=0, Valid=0 and Halted=0, regardless of state or pending stall.
REQ-028 When reset is asserted mid-fetch, the in-flight IR SHALL be discarded, and after release no fetch occurs until Start.

Verification
REQ-029 ROM[0..3]={A,B,C,D}, ROM[4]=FFFF_FFFF, Ready=1, Start pulse -> IR=A,B,C,D in four consecutive cycles with IRAddr 0..3; then Valid=0, Halted=1, Address=4 held.
REQ-030 Ready=0 for 3 cycles while IR=B -> IR=B, IRAddr=1, Valid=1 and Address=2 stable; C appears one cycle after Ready returns to 1.
REQ-031 Branch=1, Target=5 while IR=B stalled -> next cycle Valid=0 and Address=5; following cycle IR=ROM[5], IRAddr=5.
REQ-032 Memory filled with non-halt words, run to PC=31 -> the next Address is 0 and IRAddr sequence is 30, 31, 0.
REQ-033 In HALT, Branch=1, Target=2 -> Halted=0 next cycle and IR=ROM[2] the cycle after.
REQ-034 Rst_n=0 for one cycle during FETCH with Valid=1 -> all outputs zero; with Start held 0 the block stays in IDLE for 5 cycles.
